// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing two registered CDB broadcast lanes among NUM_REQ producers.
// Define CDB_ARB_STATS_EN to build the saturating deferred-result counter on conflict_cnt.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROBEN_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ROBEN_W-1:0] req_roben,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ROBEN_W-1:0]         out_ROBEN1,
  output logic [ROBEN_W-1:0]         out_ROBEN2,
  output logic [DATA_W-1:0]          out_Write_Data1,
  output logic [DATA_W-1:0]          out_Write_Data2,
  output logic [31:0]                conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_v;
  logic [ROBEN_W-1:0] buf_roben [NUM_REQ];
  logic [DATA_W-1:0]  buf_data  [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] capture;
  logic               g1_hit, g2_hit;
  logic [PTR_W-1:0]   g1_idx, g2_idx;
  logic [PTR_W-1:0]   scan;
  logic [PTR_W-1:0]   last_idx;
  logic [PTR_W-1:0]   rr_next;

  // Walk the buffers starting at rr_ptr; first two occupied ones win lanes 1 and 2.
  always_comb begin
    g1_hit = 1'b0;
    g2_hit = 1'b0;
    g1_idx = '0;
    g2_idx = '0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (buf_v[scan]) begin
        if (!g1_hit) begin
          g1_hit = 1'b1;
          g1_idx = scan;
        end else if (!g2_hit) begin
          g2_hit = 1'b1;
          g2_idx = scan;
        end
      end
    end
    grant = '0;
    if (g1_hit) grant[g1_idx] = 1'b1;
    if (g2_hit) grant[g2_idx] = 1'b1;
    last_idx = g2_hit ? g2_idx : g1_idx;
    rr_next  = PTR_W'((int'(last_idx) + 1) % NUM_REQ);
  end

  assign req_ready = {NUM_REQ{~flush}} & (~buf_v | grant);

  // A zero tag means "no result", so it never occupies a buffer.
  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      capture[i] = req_valid[i] & req_ready[i] &
                   (req_roben[i*ROBEN_W +: ROBEN_W] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v           <= '0;
      rr_ptr          <= '0;
      out_ROBEN1      <= '0;
      out_ROBEN2      <= '0;
      out_Write_Data1 <= '0;
      out_Write_Data2 <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_roben[i] <= '0;
        buf_data[i]  <= '0;
      end
    end else if (flush) begin
      buf_v           <= '0;
      out_ROBEN1      <= '0;
      out_ROBEN2      <= '0;
      out_Write_Data1 <= '0;
      out_Write_Data2 <= '0;
    end else begin
      out_ROBEN1      <= g1_hit ? buf_roben[g1_idx] : '0;
      out_Write_Data1 <= g1_hit ? buf_data[g1_idx]  : '0;
      out_ROBEN2      <= g2_hit ? buf_roben[g2_idx] : '0;
      out_Write_Data2 <= g2_hit ? buf_data[g2_idx]  : '0;
      if (g1_hit) rr_ptr <= rr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) begin
          buf_v[i]     <= 1'b1;
          buf_roben[i] <= req_roben[i*ROBEN_W +: ROBEN_W];
          buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] conflict_q;
  int          occ;

  always_comb begin
    occ = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      occ = occ + (buf_v[i] ? 1 : 0);
    end
  end

  // Counts cycles with a deferred result; flush deliberately does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
    end else if ((occ > 2) && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors on a 4-producer instance,
// plus hand sequences for async reset, tag-0 requests and 3-producer backpressure.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-producer instance
  logic         flush4;
  logic [3:0]   valid4;
  logic [19:0]  roben4;
  logic [127:0] data4;
  logic [3:0]   ready4;
  logic [4:0]   r1_4, r2_4;
  logic [31:0]  d1_4, d2_4;
  logic [31:0]  cnt4;

  cdb_arbiter #(.NUM_REQ(4), .ROBEN_W(5), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush4),
    .req_valid(valid4), .req_roben(roben4), .req_data(data4),
    .req_ready(ready4),
    .out_ROBEN1(r1_4), .out_ROBEN2(r2_4),
    .out_Write_Data1(d1_4), .out_Write_Data2(d2_4),
    .conflict_cnt(cnt4)
  );

  // 3-producer instance for the backpressure sequence
  logic         flush3;
  logic [2:0]   valid3;
  logic [23:0]  roben3;
  logic [47:0]  data3;
  logic [2:0]   ready3;
  logic [7:0]   r1_3, r2_3;
  logic [15:0]  d1_3, d2_3;
  logic [31:0]  cnt3;

  cdb_arbiter #(.NUM_REQ(3), .ROBEN_W(8), .DATA_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .req_valid(valid3), .req_roben(roben3), .req_data(data3),
    .req_ready(ready3),
    .out_ROBEN1(r1_3), .out_ROBEN2(r2_3),
    .out_Write_Data1(d1_3), .out_Write_Data2(d2_3),
    .conflict_cnt(cnt3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] valid;
    logic [4:0] t3, t2, t1, t0;
    logic       flush;
    logic [3:0] exp_ready;
    logic [4:0] exp_r1, exp_r2;
  } vec_t;

  function automatic logic [31:0] pdat(input logic [4:0] t);
    return 32'hD000_0000 | {27'd0, t};
  endfunction

  function automatic logic [31:0] edat(input logic [4:0] t);
    return (t == 5'd0) ? 32'd0 : pdat(t);
  endfunction

  task automatic drive4(input vec_t v);
    valid4 = v.valid;
    flush4 = v.flush;
    roben4 = {v.t3, v.t2, v.t1, v.t0};
    data4  = {pdat(v.t3), pdat(v.t2), pdat(v.t1), pdat(v.t0)};
  endtask

  // Backpressure scoreboard state
  int seq[3];
  int nexp[3];
  int last[3];
  int lowcnt[3];

  task automatic lane3(input logic [7:0] tag, input logic [15:0] dat, input int cyc);
    int p;
    if (tag != 8'd0) begin
      p = int'(tag[7:5]) - 1;
      if (p < 0 || p > 2) begin
        chk("bp_tag_owner", {24'd0, tag}, 32'd0);
      end else begin
        chk("bp_order", {27'd0, tag[4:0]}, nexp[p]);
        chk("bp_data", {16'd0, dat}, {16'd0, 8'hA5, tag});
        if (last[p] >= 0) begin
          checks++;
          if (cyc - last[p] > 2) begin
            errors++;
            $display("FAIL bp_fairness: producer %0d gap %0d cycles, required <= 2", p, cyc - last[p]);
          end
        end
        last[p] = cyc;
        nexp[p] = int'(tag[4:0]) + 1;
      end
    end
  endtask

  vec_t vecs[28];

  initial begin
    logic [3:0] exp_ready;
    logic [31:0] exp_cnt;

    //          valid    t3     t2     t1     t0   flush ready    r1     r2
    vecs[0]  = '{4'b0010, 5'd0,  5'd0, 5'd7,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[1]  = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd7,  5'd0};
    vecs[2]  = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[3]  = '{4'b1001, 5'd9,  5'd0, 5'd0,  5'd5,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[4]  = '{4'b1001, 5'd9,  5'd0, 5'd0,  5'd5,  1'b0, 4'b1111, 5'd9,  5'd5};
    vecs[5]  = '{4'b1001, 5'd9,  5'd0, 5'd0,  5'd5,  1'b0, 4'b1111, 5'd9,  5'd5};
    vecs[6]  = '{4'b1001, 5'd9,  5'd0, 5'd0,  5'd5,  1'b0, 4'b1111, 5'd9,  5'd5};
    vecs[7]  = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd9,  5'd5};
    vecs[8]  = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[9]  = '{4'b1000, 5'd11, 5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[10] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd11, 5'd0};
    vecs[11] = '{4'b1111, 5'd4,  5'd3, 5'd2,  5'd1,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[12] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b0011, 5'd1,  5'd2};
    vecs[13] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd3,  5'd4};
    vecs[14] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[15] = '{4'b1010, 5'd13, 5'd0, 5'd12, 5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[16] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd12, 5'd13};
    vecs[17] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[18] = '{4'b0101, 5'd0,  5'd8, 5'd0,  5'd6,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[19] = '{4'b0010, 5'd0,  5'd0, 5'd14, 5'd0,  1'b1, 4'b0000, 5'd0,  5'd0};
    vecs[20] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[21] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[22] = '{4'b1001, 5'd16, 5'd0, 5'd0,  5'd15, 1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[23] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd15, 5'd16};
    vecs[24] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[25] = '{4'b0100, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[26] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};
    vecs[27] = '{4'b0000, 5'd0,  5'd0, 5'd0,  5'd0,  1'b0, 4'b1111, 5'd0,  5'd0};

    flush4 = 1'b0; valid4 = '0; roben4 = '0; data4 = '0;
    flush3 = 1'b0; valid3 = '0; roben3 = '0; data3 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_r1", {27'd0, r1_4}, 32'd0);
    chk("reset_r2", {27'd0, r2_4}, 32'd0);
    chk("reset_d1", d1_4, 32'd0);
    chk("reset_d2", d2_4, 32'd0);
    chk("reset_cnt", cnt4, 32'd0);
    chk("reset_ready", {28'd0, ready4}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      drive4(vecs[i]);
      #1;
      chk($sformatf("row%0d_ready", i), {28'd0, ready4}, {28'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_r1", i), {27'd0, r1_4}, {27'd0, vecs[i].exp_r1});
      chk($sformatf("row%0d_r2", i), {27'd0, r2_4}, {27'd0, vecs[i].exp_r2});
      chk($sformatf("row%0d_d1", i), d1_4, edat(vecs[i].exp_r1));
      chk($sformatf("row%0d_d2", i), d2_4, edat(vecs[i].exp_r2));
    end
`ifdef CDB_ARB_STATS_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    chk("contention_cnt", cnt4, exp_cnt);

    // Continuous four-way traffic, then async reset in the middle of a cycle
    drive4('{4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, 1'b0, 4'b1111, 5'd0, 5'd0});
    repeat (3) @(posedge clk);
    #1;
    chk("traffic_r1", {27'd0, r1_4}, 32'd3);
    chk("traffic_r2", {27'd0, r2_4}, 32'd4);
`ifdef CDB_ARB_STATS_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    chk("traffic_cnt", cnt4, exp_cnt);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_r1", {27'd0, r1_4}, 32'd0);
    chk("async_rst_r2", {27'd0, r2_4}, 32'd0);
    chk("async_rst_d1", d1_4, 32'd0);
    chk("async_rst_d2", d2_4, 32'd0);
    chk("async_rst_cnt", cnt4, 32'd0);
    valid4 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {28'd0, ready4}, 32'hF);

    // Tag 0 with valid high: nothing may ever reach a lane
    drive4('{4'b1111, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b1111, 5'd0, 5'd0});
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tag0_c%0d_r1", c), {27'd0, r1_4}, 32'd0);
      chk($sformatf("tag0_c%0d_d1", c), d1_4, 32'd0);
      chk($sformatf("tag0_c%0d_d2", c), d2_4, 32'd0);
      chk($sformatf("tag0_c%0d_ready", c), {28'd0, ready4}, 32'hF);
    end
    valid4 = '0;

    // Backpressure on the 3-producer instance, all producers always offering
    chk("bp_cnt_start", cnt3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0; nexp[i] = 0; last[i] = -1; lowcnt[i] = 0;
    end
    for (int cyc = 0; cyc < 28; cyc++) begin
      valid3 = (cyc < 24) ? 3'b111 : 3'b000;
      for (int i = 0; i < 3; i++) begin
        roben3[i*8 +: 8]  = 8'((i + 1) << 5) | 8'(seq[i]);
        data3[i*16 +: 16] = {8'hA5, roben3[i*8 +: 8]};
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (valid3[i] && !ready3[i]) lowcnt[i]++;
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (valid3[i] && ready3[i]) seq[i]++;
      end
      #1;
      lane3(r1_3, d1_3, cyc);
      lane3(r2_3, d2_3, cyc);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_all_delivered_p%0d", i), nexp[i], seq[i]);
      chk($sformatf("bp_ready_rotates_p%0d", i), {31'd0, lowcnt[i] > 0}, 32'd1);
    end
    chk("bp_lanes_idle_r1", {24'd0, r1_3}, 32'd0);
    chk("bp_lanes_idle_r2", {24'd0, r2_3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
